project1_lcd_ctrl: RTL and testbench

Parametrised successor to the 12-bit LCD output port. It replaces software bit-banging of the character LCD with an Avalon-MM slave that queues commands and characters in a FIFO. A sequencer drives each queued byte onto an HD44780-style 8-bit bus with programmable setup, enable-pulse, hold and busy-wait timing. It sits on the system interconnect in place of the plain output port, and its register reads are zero-wait-state.

---
 rtl/project1_lcd_ctrl.sv | 179 +++++++++++++++++
 tb/tb_project1_lcd_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/project1_lcd_ctrl.sv
// Avalon-MM character-LCD controller: queues command/character bytes in a FIFO and
// replays them onto an HD44780-style 8-bit bus with programmable bus timing.
module project1_lcd_ctrl #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned PULSE_CYC    = 12,
    parameter int unsigned HOLD_CYC     = 4,
    parameter int unsigned WAIT_W       = 20,
    parameter int unsigned WAIT_DEFAULT = 2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (WAIT_W > 16) ? WAIT_W : 16;

    // A timing parameter of 0 behaves as 1, i.e. a reload value of 0.
    localparam logic [CW-1:0] SETUP_LD = (SETUP_CYC == 0) ? '0 : CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = (PULSE_CYC == 0) ? '0 : CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = (HOLD_CYC == 0)  ? '0 : CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [8:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              enable_q, ovf_q;
    logic [WAIT_W-1:0] wait_q;

    logic wr_en, push_req, flush, empty, full, pop, push_ok, ovf_set, busy;
    logic [8:0] head;

    assign wr_en    = chipselect & ~write_n;
    assign push_req = wr_en & (address == 2'd0);
    assign flush    = wr_en & (address == 2'd1) & writedata[1];
    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign pop      = (state_q == StIdle) & enable_q & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    assign push_ok  = push_req & ~flush & (~full | pop);
    assign ovf_set  = push_req & ~flush & full & ~pop;
    assign busy     = (state_q != StIdle);
    assign head     = mem[rd_ptr_q];

    logic unused_wdata;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= writedata[8:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q <= 1'b0;
            wait_q   <= WAIT_W'(WAIT_DEFAULT);
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en && address == 2'd1) enable_q <= writedata[0];
            if (wr_en && address == 2'd2) wait_q   <= writedata[WAIT_W-1:0];
            if (ovf_set)                                         ovf_q <= 1'b1;
            else if (wr_en && address == 2'd3 && writedata[0])   ovf_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StSetup;
                    cnt_d   = SETUP_LD;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StPulse;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    // The wait length is captured here; later rewrites don't disturb it.
                    if (wait_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CW'(wait_q) - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) begin
                lcd_rs   <= head[8];
                lcd_data <= head[7:0];
            end
        end
    end

    assign lcd_en = (state_q == StPulse);
    assign lcd_rw = 1'b0;

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                readdata[0]    = empty;
                readdata[1]    = full;
                readdata[2]    = busy;
                readdata[3]    = ovf_q;
                readdata[15:8] = 8'(level_q);
            end
            2'd1:    readdata[0] = enable_q;
            2'd2:    readdata    = 32'(wait_q);
            default: readdata[0] = ovf_q;
        endcase
    end

endmodule

// File: tb/tb_project1_lcd_ctrl.sv
// Scoreboard bench for project1_lcd_ctrl: expected LCD words are queued at write time
// and compared when each lcd_en pulse starts; bus timing is checked by cycle number.
module tb_project1_lcd_ctrl;

    localparam int DEPTH = 16;
    localparam int SETUP = 4;
    localparam int PULSE = 12;
    localparam int HOLD  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;

    project1_lcd_ctrl #(
        .DEPTH(DEPTH), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD),
        .WAIT_W(20), .WAIT_DEFAULT(2000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cyc = 0;
    int rise_cnt = 0;
    int last_rise = 0;
    int last_fall = 0;
    logic [8:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard at each lcd_en rise and checks pulse width.
    initial begin
        logic en_prev;
        int   width;
        logic [8:0] e;
        en_prev = 1'b0;
        width   = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                en_prev = 1'b0;
                width   = 0;
            end else begin
                if (lcd_en && !en_prev) begin
                    rise_cnt++;
                    last_rise = cyc;
                    width     = 1;
                    if (exp_q.size() == 0) begin
                        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("lcd_word", {23'd0, lcd_rs, lcd_data}, {23'd0, e});
                    end
                    check_eq("lcd_rw", {31'd0, lcd_rw}, 32'd0);
                end else if (lcd_en) begin
                    width++;
                end
                if (!lcd_en && en_prev) begin
                    last_fall = cyc;
                    check_eq("pulse_width", width, PULSE);
                end
                en_prev = lcd_en;
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        wr_cyc     = cyc;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int done);
        logic [31:0] rd;
        rd = '1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            bus_read(2'd0, rd);
            if (!rd[2]) break;
        end
        done = cyc;
        check_eq(tag, {31'd0, rd[2]}, 32'd0);
    endtask

    task automatic wait_rises(input string tag, input int target);
        for (int n = 0; n < 200 && rise_cnt < target; n++) begin
            @(negedge clk);
            #1;
        end
        check_eq(tag, rise_cnt, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int n, done, r0;

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_en",   {31'd0, lcd_en}, 32'd0);
        check_eq("rst_word", {23'd0, lcd_rs, lcd_data}, 32'd0);
        check_eq("rst_rw",   {31'd0, lcd_rw}, 32'd0);
        bus_read(2'd0, rd); check_eq("rst_status", rd, 32'h1);
        bus_read(2'd1, rd); check_eq("rst_ctrl",   rd, 32'h0);
        bus_read(2'd2, rd); check_eq("rst_wait",   rd, 32'd2000);
        bus_read(2'd3, rd); check_eq("rst_ovf",    rd, 32'h0);

        // Single transaction timing
        bus_write(2'd2, 32'd10);
        bus_write(2'd1, 32'h1);
        exp_q.push_back(9'h138);
        bus_write(2'd0, 32'h138);
        n = wr_cyc;
        @(posedge clk);
        #1;
        check_eq("t1_latch", {23'd0, lcd_rs, lcd_data}, 32'h138);
        wait_idle("t1_idle", done);
        check_eq("t1_rise_cyc", last_rise, n + 1 + SETUP);
        check_eq("t1_fall_cyc", last_fall, n + 1 + SETUP + PULSE);
        check_eq("t1_busy_len", done - n, 1 + SETUP + PULSE + HOLD + 10);

        // Overflow
        bus_write(2'd1, 32'h0);
        for (int i = 0; i <= DEPTH; i++) bus_write(2'd0, 32'(i));
        bus_read(2'd0, rd); check_eq("t2_status_full", rd, 32'h0000_100A);
        bus_read(2'd3, rd); check_eq("t2_ovf_set", rd, 32'h1);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rd); check_eq("t2_ovf_clr", rd, 32'h0);
        bus_read(2'd0, rd); check_eq("t2_status_clr", rd, 32'h0000_1002);

        // Flush
        bus_write(2'd1, 32'h2);
        bus_read(2'd0, rd); check_eq("t3_flush_empty", rd, 32'h1);
        for (int i = 0; i < 3; i++) bus_write(2'd0, 32'h100 | 32'(i));
        bus_read(2'd0, rd); check_eq("t3_level3", rd, 32'h0000_0300);
        r0 = rise_cnt;
        bus_write(2'd1, 32'h3);
        bus_read(2'd0, rd); check_eq("t3_flushed", rd, 32'h1);
        bus_read(2'd1, rd); check_eq("t3_ctrl", rd, 32'h1);
        repeat (30) @(posedge clk);
        #1;
        check_eq("t3_no_pulse", rise_cnt, r0);

        // Back-to-back with WAIT=0
        bus_write(2'd2, 32'd0);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h141);
        r0 = rise_cnt;
        bus_write(2'd0, 32'h001);
        bus_write(2'd0, 32'h141);
        wait_rises("t4_rises", r0 + 2);
        check_eq("t4_gap", last_rise - last_fall, HOLD + 1 + SETUP);
        wait_idle("t4_idle", done);
        bus_read(2'd0, rd); check_eq("t4_status", rd, 32'h1);

        // Disable mid-pulse
        bus_write(2'd2, 32'd3);
        bus_write(2'd1, 32'h0);
        exp_q.push_back(9'h055);
        exp_q.push_back(9'h166);
        bus_write(2'd0, 32'h055);
        bus_write(2'd0, 32'h166);
        r0 = rise_cnt;
        bus_write(2'd1, 32'h1);
        wait_rises("t5_rise", r0 + 1);
        repeat (3) @(posedge clk);
        #1;
        bus_write(2'd1, 32'h0);
        wait_idle("t5_idle", done);
        bus_read(2'd0, rd); check_eq("t5_status", rd, 32'h0000_0100);
        repeat (30) @(posedge clk);
        #1;
        check_eq("t5_one_pulse", rise_cnt, r0 + 1);

        // Reset during pulse
        bus_write(2'd1, 32'h1);
        wait_rises("t6_rise", r0 + 2);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("t6_en_drop", {31'd0, lcd_en}, 32'd0);
        check_eq("t6_word",    {23'd0, lcd_rs, lcd_data}, 32'd0);
        bus_read(2'd0, rd); check_eq("t6_status", rd, 32'h1);
        bus_read(2'd1, rd); check_eq("t6_ctrl",   rd, 32'h0);
        bus_read(2'd2, rd); check_eq("t6_wait",   rd, 32'd2000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("t6_no_pulse", rise_cnt, r0 + 2);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
